// File: rtl/bricks_game_sequencer.sv
// rtl/bricks_game_sequencer.sv - Bricks round sequencer: serve/play/level/over flow, move strobe, lives and level
// Optional pause support is compiled in when BRICKS_PAUSE_EN is defined.
module bricks_game_sequencer #(
    parameter int unsigned LIVES       = 3,
    parameter int unsigned MAX_LEVEL   = 3,
    parameter int unsigned BASE_DIV    = 4,
    parameter int unsigned SERVE_TICKS = 4,
    parameter logic [3:0]  KEY_START   = 4'hA,
    parameter logic [3:0]  KEY_PAUSE   = 4'hB
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] control,
    input  logic       ball_lost,
    input  logic       bricks_cleared,
    output logic [2:0] state,
    output logic       move_en,
    output logic       ball_reload,
    output logic       bricks_reload,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [2:0] serve_count,
    output logic       game_over
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SERVE    = 3'd1;
    localparam logic [2:0] S_PLAY     = 3'd2;
    localparam logic [2:0] S_PAUSE    = 3'd3;
    localparam logic [2:0] S_LEVEL_UP = 3'd4;
    localparam logic [2:0] S_OVER     = 3'd5;

    localparam logic [1:0] LIVES_W     = 2'(LIVES);
    localparam logic [2:0] MAX_LEVEL_W = 3'(MAX_LEVEL);
    localparam logic [3:0] BASE_DIV_W  = 4'(BASE_DIV);
    localparam logic [2:0] SERVE_W     = 3'(SERVE_TICKS);

    logic [2:0] state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [2:0] level_q, level_d;
    logic [2:0] serve_count_q, serve_count_d;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic       move_en_q, move_en_d;
    logic       ball_reload_q, ball_reload_d;
    logic       bricks_reload_q, bricks_reload_d;
    logic       game_over_q, game_over_d;
    logic [3:0] ctrl_prev_q, ctrl_prev_d;

    logic       start_press;
    logic [3:0] period;

    assign start_press = (control == KEY_START) && (ctrl_prev_q != KEY_START);

`ifdef BRICKS_PAUSE_EN
    logic pause_press;
    assign pause_press = (control == KEY_PAUSE) && (ctrl_prev_q != KEY_PAUSE);
`else
    logic unused_key_pause;
    assign unused_key_pause = ^KEY_PAUSE;
`endif

    // Higher levels move faster; never below one tick per move.
    always_comb begin
        period = 4'd1;
        if (BASE_DIV_W > {1'b0, level_q}) begin
            period = BASE_DIV_W - {1'b0, level_q};
        end
    end

    always_comb begin
        state_d         = state_q;
        lives_d         = lives_q;
        level_d         = level_q;
        serve_count_d   = serve_count_q;
        div_cnt_d       = div_cnt_q;
        move_en_d       = 1'b0;
        ball_reload_d   = 1'b0;
        bricks_reload_d = 1'b0;
        ctrl_prev_d     = control;

        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_press) begin
                    state_d         = S_SERVE;
                    lives_d         = LIVES_W;
                    level_d         = 3'd0;
                    serve_count_d   = SERVE_W;
                    ball_reload_d   = 1'b1;
                    bricks_reload_d = 1'b1;
                end
            end
            S_SERVE: begin
                if (tick) begin
                    serve_count_d = serve_count_q - 3'd1;
                    if (serve_count_q <= 3'd1) begin
                        serve_count_d = 3'd0;
                        state_d       = S_PLAY;
                        div_cnt_d     = 4'd0;
                    end
                end
            end
            S_PLAY: begin
                // A cleared wall wins over a simultaneous lost ball.
                if (bricks_cleared) begin
                    state_d = S_LEVEL_UP;
                end else if (ball_lost) begin
                    if (lives_q > 2'd1) begin
                        lives_d       = lives_q - 2'd1;
                        ball_reload_d = 1'b1;
                        serve_count_d = SERVE_W;
                        state_d       = S_SERVE;
                    end else begin
                        lives_d = 2'd0;
                        state_d = S_OVER;
                    end
                end
`ifdef BRICKS_PAUSE_EN
                else if (pause_press) begin
                    state_d = S_PAUSE;
                end
`endif
                else if (tick) begin
                    if (div_cnt_q >= period - 4'd1) begin
                        move_en_d = 1'b1;
                        div_cnt_d = 4'd0;
                    end else begin
                        div_cnt_d = div_cnt_q + 4'd1;
                    end
                end
            end
`ifdef BRICKS_PAUSE_EN
            S_PAUSE: begin
                if (pause_press) begin
                    state_d = S_PLAY;
                end
            end
`endif
            S_LEVEL_UP: begin
                level_d         = (level_q >= MAX_LEVEL_W) ? MAX_LEVEL_W : level_q + 3'd1;
                ball_reload_d   = 1'b1;
                bricks_reload_d = 1'b1;
                serve_count_d   = SERVE_W;
                state_d         = S_SERVE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            lives_q         <= LIVES_W;
            level_q         <= 3'd0;
            serve_count_q   <= 3'd0;
            div_cnt_q       <= 4'd0;
            move_en_q       <= 1'b0;
            ball_reload_q   <= 1'b0;
            bricks_reload_q <= 1'b0;
            game_over_q     <= 1'b0;
            ctrl_prev_q     <= 4'd0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            level_q         <= level_d;
            serve_count_q   <= serve_count_d;
            div_cnt_q       <= div_cnt_d;
            move_en_q       <= move_en_d;
            ball_reload_q   <= ball_reload_d;
            bricks_reload_q <= bricks_reload_d;
            game_over_q     <= game_over_d;
            ctrl_prev_q     <= ctrl_prev_d;
        end
    end

    assign state         = state_q;
    assign lives         = lives_q;
    assign level         = level_q;
    assign serve_count   = serve_count_q;
    assign move_en       = move_en_q;
    assign ball_reload   = ball_reload_q;
    assign bricks_reload = bricks_reload_q;
    assign game_over     = game_over_q;

endmodule

// File: tb/tb_bricks_game_sequencer.sv
// tb/tb_bricks_game_sequencer.sv - directed and randomized bench for bricks_game_sequencer against a behavioural game model
module tb_bricks_game_sequencer;

    localparam int         LIVES       = 3;
    localparam int         MAX_LEVEL   = 3;
    localparam int         BASE_DIV    = 4;
    localparam int         SERVE_TICKS = 4;
    localparam logic [3:0] KEY_START   = 4'hA;
    localparam logic [3:0] KEY_PAUSE   = 4'hB;

`ifdef BRICKS_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSE = 3, M_LVL = 4, M_OVER = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] control = 4'd0;
    logic       ball_lost = 1'b0;
    logic       bricks_cleared = 1'b0;
    logic [2:0] state;
    logic       move_en;
    logic       ball_reload;
    logic       bricks_reload;
    logic [1:0] lives;
    logic [2:0] level;
    logic [2:0] serve_count;
    logic       game_over;

    bricks_game_sequencer #(
        .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL), .BASE_DIV(BASE_DIV),
        .SERVE_TICKS(SERVE_TICKS), .KEY_START(KEY_START), .KEY_PAUSE(KEY_PAUSE)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick), .control(control),
        .ball_lost(ball_lost), .bricks_cleared(bricks_cleared),
        .state(state), .move_en(move_en), .ball_reload(ball_reload),
        .bricks_reload(bricks_reload), .lives(lives), .level(level),
        .serve_count(serve_count), .game_over(game_over)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int         m_state, m_lives, m_level, m_serve, m_div;
    int         m_move, m_brel, m_bkrel;
    logic [3:0] m_prev;

    int exp_period [4] = '{3, 2, 1, 1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE; m_lives = LIVES; m_level = 0; m_serve = 0; m_div = 0;
        m_move = 0; m_brel = 0; m_bkrel = 0; m_prev = 4'd0;
    endtask

    // One clock of game rules: what the registered outputs must show after this edge.
    task automatic model_step(input logic t, input logic [3:0] c, input logic bl, input logic bc);
        logic sp, pp;
        int   p;
        sp = (c == KEY_START) && (m_prev != KEY_START);
        pp = (c == KEY_PAUSE) && (m_prev != KEY_PAUSE);
        m_move = 0; m_brel = 0; m_bkrel = 0;
        case (m_state)
            M_IDLE, M_OVER: if (sp) begin
                m_state = M_SERVE; m_lives = LIVES; m_level = 0; m_serve = SERVE_TICKS;
                m_brel = 1; m_bkrel = 1;
            end
            M_SERVE: if (t) begin
                m_serve = m_serve - 1;
                if (m_serve == 0) begin m_state = M_PLAY; m_div = 0; end
            end
            M_PLAY: begin
                if (bc) m_state = M_LVL;
                else if (bl) begin
                    if (m_lives > 1) begin
                        m_lives = m_lives - 1; m_brel = 1; m_state = M_SERVE; m_serve = SERVE_TICKS;
                    end else begin
                        m_lives = 0; m_state = M_OVER;
                    end
                end else if (PAUSE_EN && pp) m_state = M_PAUSE;
                else if (t) begin
                    p = BASE_DIV - m_level;
                    if (p < 1) p = 1;
                    m_div = m_div + 1;
                    if (m_div == p) begin m_move = 1; m_div = 0; end
                end
            end
            M_PAUSE: if (pp) m_state = M_PLAY;
            M_LVL: begin
                m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
                m_brel = 1; m_bkrel = 1; m_state = M_SERVE; m_serve = SERVE_TICKS;
            end
            default: m_state = M_IDLE;
        endcase
        m_prev = c;
    endtask

    task automatic compare_all();
        check("state", state, m_state);
        check("lives", lives, m_lives);
        check("level", level, m_level);
        check("serve_count", serve_count, m_serve);
        check("move_en", move_en, m_move);
        check("ball_reload", ball_reload, m_brel);
        check("bricks_reload", bricks_reload, m_bkrel);
        check("game_over", game_over, (m_state == M_OVER) ? 1 : 0);
    endtask

    task automatic cycle(input logic t, input logic [3:0] c, input logic bl, input logic bc);
        tick = t; control = c; ball_lost = bl; bricks_cleared = bc;
        model_step(t, c, bl, bc);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic serve4();
        repeat (SERVE_TICKS) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
            cycle(1'b1, 4'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks_to_move(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
            cycle(1'b1, 4'd0, 1'b0, 1'b0);
            n++;
            if (move_en) break;
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int   n, moves;
        logic t, prev_t, bl, prev_bl, bc;
        logic [3:0] c;

        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", state, 0);
        check("rst_lives", lives, LIVES);
        check("rst_move_en", move_en, 0);
        compare_all();
        reset = 1'b1;

        cycle(1'b0, KEY_START, 1'b0, 1'b0);
        check("start_state", state, 1);
        check("start_ball_reload", ball_reload, 1);
        check("start_bricks_reload", bricks_reload, 1);
        check("start_lives", lives, 3);
        repeat (9) cycle(1'b0, KEY_START, 1'b0, 1'b0);
        check("hold_no_reload", ball_reload, 0);
        check("hold_state", state, 1);

        ticks_to_move(n);
        check("first_move_latency", n, SERVE_TICKS + BASE_DIV);
        ticks_to_move(n);
        check("period_level0", n, BASE_DIV);

        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 4'd0, 1'b1, 1'b0);
            if (k < 2) begin
                check("lost_lives", lives, 2 - k);
                check("lost_reload", ball_reload, 1);
                serve4();
                check("lost_replay", state, 2);
            end else begin
                check("over_state", state, 5);
                check("over_flag", game_over, 1);
                check("over_lives", lives, 0);
            end
        end
        cycle(1'b0, KEY_START, 1'b0, 1'b0);
        check("restart_lives", lives, 3);
        check("restart_state", state, 1);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        serve4();

        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b1);
            check("levelup_state", state, 4);
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
            check("level_value", level, (k + 1 > MAX_LEVEL) ? MAX_LEVEL : k + 1);
            serve4();
            ticks_to_move(n);
            check("level_period", n, exp_period[k]);
        end

        cycle(1'b0, 4'd0, 1'b1, 1'b1);
        check("clear_beats_lost", state, 4);
        check("clear_keeps_lives", lives, 3);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        serve4();
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        cycle(1'b1, 4'd0, 1'b0, 1'b0);

        reset = 1'b0;
        #2;
        check("arst_state", state, 0);
        check("arst_lives", lives, LIVES);
        check("arst_level", level, 0);
        check("arst_serve", serve_count, 0);
        check("arst_move", move_en, 0);
        check("arst_game_over", game_over, 0);
        model_reset();
        @(posedge clock);
        #1;
        compare_all();
        reset = 1'b1;
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        check("release_state", state, 0);
        check("release_ball_reload", ball_reload, 0);
        check("release_bricks_reload", bricks_reload, 0);

        cycle(1'b0, KEY_START, 1'b0, 1'b0);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        serve4();
        repeat (2) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
            cycle(1'b1, 4'd0, 1'b0, 1'b0);
        end
        cycle(1'b0, KEY_PAUSE, 1'b0, 1'b0);
`ifdef BRICKS_PAUSE_EN
        check("pause_state", state, 3);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        moves = 0;
        repeat (10) begin
            cycle(1'b0, 4'd0, 1'b0, 1'b0);
            cycle(1'b1, 4'd0, 1'b0, 1'b0);
            moves += int'(move_en);
        end
        cycle(1'b0, 4'd0, 1'b1, 1'b0);
        moves += int'(move_en);
        check("pause_no_move", moves, 0);
        check("pause_lives", lives, 3);
        cycle(1'b0, KEY_PAUSE, 1'b0, 1'b0);
        check("resume_state", state, 2);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
        ticks_to_move(n);
        check("resume_ticks", n, 2);
`else
        check("nopause_state", state, 2);
        cycle(1'b0, 4'd0, 1'b0, 1'b0);
`endif

        prev_t = 1'b0; prev_bl = 1'b0; bc = 1'b0; c = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            t  = !prev_t && ($urandom_range(0, 2) == 0);
            bl = !prev_bl && ($urandom_range(0, 24) == 0);
            if (bc) bc = ($urandom_range(0, 2) != 0);
            else    bc = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       c = 4'd0;
                    1:       c = KEY_START;
                    2:       c = KEY_PAUSE;
                    default: c = 4'($urandom_range(0, 15));
                endcase
            end
            cycle(t, c, bl, bc);
            prev_t = t; prev_bl = bl;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
